// File: rtl/clkswitch_pkg.sv
// ---------------------------------------------------------------------------
// clkswitch_pkg : state encoding and default sizing for the clock-switch requester
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clkswitch_pkg;

   localparam logic [1:0] LS_RUN = 2'd0;
   localparam logic [1:0] TO_HS  = 2'd1;
   localparam logic [1:0] HS_RUN = 2'd2;
   localparam logic [1:0] TO_LS  = 2'd3;

   localparam int C_SYNC_STAGES    = 2;
   localparam int C_DWELL_CYCLES   = 8;
   localparam int C_TIMEOUT_CYCLES = 255;
   localparam int C_CNT_W          = 8;

endpackage

`default_nettype wire

// File: rtl/clkswitch_sync.sv
// ---------------------------------------------------------------------------
// clkswitch_sync : STAGES-deep status synchroniser with a configurable reset value
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clkswitch_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_b,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_chain <= {STAGES{RST_VAL}};
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/clkswitch_req.sv
// ---------------------------------------------------------------------------
// clkswitch_req : requester side of the HS/LS CPU clock-switch handshake
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clkswitch_req
   import clkswitch_pkg::*;
#(
   parameter int SYNC_STAGES    = C_SYNC_STAGES,
   parameter int DWELL_CYCLES   = C_DWELL_CYCLES,
   parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES,
   parameter int CNT_W          = C_CNT_W
) (
   input  logic       hsclk_in,
   input  logic       rst_b,
   input  logic       ls_req,
   input  logic       hs_allowed,
   input  logic       err_clr,
   input  logic       hsclk_selected,
   input  logic       lsclk_selected,
   output logic       hsclk_sel,
   output logic       cpu_rdy,
   output logic       switching,
   output logic       timeout_err,
   output logic [1:0] state_o
);

   localparam logic [CNT_W-1:0] c_DWELL   = CNT_W'(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

   logic             w_hs_s;
   logic             w_ls_s;
   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_hsclk_sel;
   logic             w_sel_nxt;
   logic [CNT_W-1:0] r_dwell_cnt;
   logic [CNT_W-1:0] w_dwell_nxt;
   logic [CNT_W-1:0] r_to_cnt;
   logic [CNT_W-1:0] w_to_nxt;
   logic             w_err_set;
   logic             r_switching;
   logic             r_timeout_err;

   // Reset values mirror the controller's own reset state: LS selected, HS gated off.
   clkswitch_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_hs (
      .clk   (hsclk_in),
      .rst_b (rst_b),
      .i_d   (hsclk_selected),
      .o_q   (w_hs_s)
   );

   clkswitch_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ls (
      .clk   (hsclk_in),
      .rst_b (rst_b),
      .i_d   (lsclk_selected),
      .o_q   (w_ls_s)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_hsclk_sel;
      w_dwell_nxt = r_dwell_cnt;
      w_to_nxt    = r_to_cnt;
      w_err_set   = 1'b0;
      case (r_state)
         LS_RUN: begin
            if (r_dwell_cnt != '0) begin
               w_dwell_nxt = r_dwell_cnt - c_ONE;
            end
            if (hs_allowed && !ls_req && (r_dwell_cnt == '0)) begin
               w_state_nxt = TO_HS;
               w_sel_nxt   = 1'b1;
               w_to_nxt    = '0;
            end
         end
         TO_HS: begin
            // A late ls_req does not abort; HS_RUN is left on the following cycle.
            if (r_to_cnt != c_TIMEOUT) begin
               w_to_nxt = r_to_cnt + c_ONE;
            end
            if (w_hs_s && !w_ls_s) begin
               w_state_nxt = HS_RUN;
            end else if (r_to_cnt == c_TIMEOUT) begin
               w_err_set   = 1'b1;
               w_sel_nxt   = 1'b0;
               w_state_nxt = TO_LS;
               w_to_nxt    = '0;
            end
         end
         HS_RUN: begin
            if (ls_req || !hs_allowed) begin
               w_state_nxt = TO_LS;
               w_sel_nxt   = 1'b0;
               w_to_nxt    = '0;
            end
         end
         TO_LS: begin
            w_sel_nxt = 1'b0;
            if (r_to_cnt != c_TIMEOUT) begin
               w_to_nxt = r_to_cnt + c_ONE;
            end
            if (w_ls_s && !w_hs_s) begin
               w_state_nxt = LS_RUN;
               w_dwell_nxt = c_DWELL;
            end else if (r_to_cnt == c_TIMEOUT) begin
               w_err_set = 1'b1;
            end
         end
         default: begin
            w_state_nxt = LS_RUN;
            w_sel_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge hsclk_in) begin
      if (!rst_b) begin
         r_state       <= LS_RUN;
         r_hsclk_sel   <= 1'b0;
         r_dwell_cnt   <= c_DWELL;
         r_to_cnt      <= '0;
         r_switching   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hsclk_sel <= w_sel_nxt;
         r_dwell_cnt <= w_dwell_nxt;
         r_to_cnt    <= w_to_nxt;
         r_switching <= (w_state_nxt == TO_HS) || (w_state_nxt == TO_LS);
         if (w_err_set) begin
            r_timeout_err <= 1'b1;
         end else if (err_clr) begin
            r_timeout_err <= 1'b0;
         end
      end
   end

   assign cpu_rdy     = (r_state == LS_RUN) ||
                        ((r_state == HS_RUN) && !ls_req && hs_allowed);
   assign hsclk_sel   = r_hsclk_sel;
   assign switching   = r_switching;
   assign timeout_err = r_timeout_err;
   assign state_o     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_clkswitch_req.sv
// ---------------------------------------------------------------------------
// tb_clkswitch_req : directed self-checking bench with a 3-cycle echo controller model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clkswitch_req;
   import clkswitch_pkg::*;

   logic       hsclk_in = 1'b0;
   logic       rst_b = 1'b0;
   logic       ls_req = 1'b0;
   logic       hs_allowed = 1'b1;
   logic       err_clr = 1'b0;
   logic       hsclk_selected;
   logic       lsclk_selected;
   logic       hsclk_sel;
   logic       cpu_rdy;
   logic       switching;
   logic       timeout_err;
   logic [1:0] state_o;

   logic [2:0] r_pipe = 3'b000;
   logic       dead = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         k;

   clkswitch_req dut (
      .hsclk_in       (hsclk_in),
      .rst_b          (rst_b),
      .ls_req         (ls_req),
      .hs_allowed     (hs_allowed),
      .err_clr        (err_clr),
      .hsclk_selected (hsclk_selected),
      .lsclk_selected (lsclk_selected),
      .hsclk_sel      (hsclk_sel),
      .cpu_rdy        (cpu_rdy),
      .switching      (switching),
      .timeout_err    (timeout_err),
      .state_o        (state_o)
   );

   always #5 hsclk_in = ~hsclk_in;

   // Controller model: status follows hsclk_sel three edges later; 'dead' pins it to LS.
   always @(posedge hsclk_in) r_pipe <= {r_pipe[1:0], hsclk_sel};
   assign hsclk_selected = r_pipe[2] & !dead;
   assign lsclk_selected = !r_pipe[2] | dead;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_s(input string tag, input logic [1:0] st, input logic sel, input logic rdy);
      chk({tag, ".state"}, state_o, st);
      chk({tag, ".hsclk_sel"}, hsclk_sel, sel);
      chk({tag, ".cpu_rdy"}, cpu_rdy, rdy);
      chk({tag, ".switching"}, switching, st[0]);
   endtask

   task automatic step;
      @(posedge hsclk_in);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step; step;
      chk_s("reset", LS_RUN, 1'b0, 1'b1);
      chk("reset.timeout_err", timeout_err, 1'b0);
      chk("reset.dwell", dut.r_dwell_cnt, 8);
      rst_b = 1'b1;

      // Dwell of 8 edges, then TO_HS on the ninth; HS_RUN 3 (model) + 2 (sync) + 1 edges later
      for (int i = 1; i <= 8; i++) begin
         step;
         chk_s("dwell1", LS_RUN, 1'b0, 1'b1);
      end
      step;
      chk_s("to_hs_entry", TO_HS, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step;
         chk_s("to_hs_wait", TO_HS, 1'b1, 1'b0);
      end
      step;
      chk_s("hs_run", HS_RUN, 1'b1, 1'b1);
      step;
      chk_s("hs_run2", HS_RUN, 1'b1, 1'b1);

      // ls_req pulse in HS_RUN: combinational stall, then TO_LS
      ls_req = 1'b1;
      #1;
      chk_s("ls_req_same_cycle", HS_RUN, 1'b1, 1'b0);
      step;
      chk_s("to_ls_entry", TO_LS, 1'b0, 1'b0);
      ls_req = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step;
         chk_s("to_ls_wait", TO_LS, 1'b0, 1'b0);
      end
      step;
      chk_s("ls_back", LS_RUN, 1'b0, 1'b1);
      chk("ls_back.dwell", dut.r_dwell_cnt, 8);
      for (int i = 1; i <= 8; i++) begin
         step;
         chk_s("dwell2", LS_RUN, 1'b0, 1'b1);
      end
      step;
      chk_s("to_hs_again", TO_HS, 1'b1, 1'b0);

      // ls_req during TO_HS: complete to HS_RUN, leave next cycle, never ready
      ls_req = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step;
         chk_s("to_hs_lsreq", TO_HS, 1'b1, 1'b0);
      end
      step;
      chk_s("hs_run_lsreq", HS_RUN, 1'b1, 1'b0);
      step;
      chk_s("to_ls_lsreq", TO_LS, 1'b0, 1'b0);
      step;
      chk_s("to_ls_mid", TO_LS, 1'b0, 1'b0);

      // One-cycle reset mid TO_LS
      rst_b = 1'b0;
      step;
      chk_s("midreset", LS_RUN, 1'b0, 1'b1);
      chk("midreset.dwell", dut.r_dwell_cnt, 8);
      rst_b  = 1'b1;
      ls_req = 1'b0;
      dead   = 1'b1;

      // Dead controller: TO_HS times out when to_cnt has reached 255
      for (int i = 1; i <= 8; i++) step;
      step;
      chk_s("dead_to_hs", TO_HS, 1'b1, 1'b0);
      for (int i = 1; i <= 255; i++) step;
      chk_s("dead_t255", TO_HS, 1'b1, 1'b0);
      chk("dead_t255.err", timeout_err, 1'b0);
      step;
      chk_s("timeout", TO_LS, 1'b0, 1'b0);
      chk("timeout.err", timeout_err, 1'b1);
      step;
      chk_s("timeout_ls", LS_RUN, 1'b0, 1'b1);
      chk("timeout_ls.err", timeout_err, 1'b1);
      err_clr = 1'b1;
      step;
      err_clr = 1'b0;
      chk("err_clr", timeout_err, 1'b0);

      // Second timeout with err_clr on the same edge: set wins
      k = 0;
      while (state_o !== TO_HS && k < 20) begin
         step;
         k++;
      end
      chk("dwell3_len", k, 8);
      for (int i = 1; i <= 255; i++) step;
      chk_s("dead2_t255", TO_HS, 1'b1, 1'b0);
      err_clr = 1'b1;
      step;
      err_clr = 1'b0;
      chk_s("timeout2", TO_LS, 1'b0, 1'b0);
      chk("set_beats_clr", timeout_err, 1'b1);
      step;
      chk_s("timeout2_ls", LS_RUN, 1'b0, 1'b1);
      chk("timeout2_ls.err", timeout_err, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
